instruction_fetch: RTL and testbench

Program-counter and fetch-sequencing stage directly upstream of `InstructionMemory`. It drives the memory's `rd_en`/`rd_addr`, captures the returned `instruction` one cycle later into a 2-entry buffer, and presents each word with its byte PC to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_skid_fifo.sv | 47 ++++
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_WIDTH     = 32;
  localparam int ENTRY_INST_W = 32;
  localparam logic [PC_WIDTH-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ENTRY_INST_W-1:0] instruction;
    logic [PC_WIDTH-1:0]     pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO holding fetched {instruction, pc} pairs ahead of decode.
// Occupancy and pointers are reset; the storage array is not, since nothing
// reads it while the count is zero.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // Entry storage written at the write pointer.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Program counter and fetch sequencer in front of InstructionMemory.
// Issues one read per cycle, captures the returned word on the next edge
// into a two-entry FIFO, and hands words to decode over valid/ready.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts
// fetch and raises a sticky flag; without it the low pc bits are dropped).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                  INST_WIDTH = 32,
  parameter int                  INST_DEPTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0,
  localparam int                 AW         = $clog2(INST_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_rd_addr,
  input  logic [INST_WIDTH-1:0] mem_instruction,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  fetch_misaligned
);

  fetch_state_t        r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_inflight_pc;
  logic                r_inflight;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                r_misaligned;
`endif

  logic [1:0]   w_count;
  logic [1:0]   w_occ;
  logic         w_pop;
  logic         w_push;
  logic         w_kill;
  logic         w_issue;
  fetch_entry_t w_head;
  fetch_entry_t w_entry;

  // A redirect both flushes the buffer and kills the read in flight.
  assign w_kill    = redirect_valid;
  assign out_valid = (w_count != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_inflight && !w_kill;

  // Slots committed after this edge: buffered plus in flight, minus the word
  // decode takes now. Counting the pop keeps a full-rate stream with only two
  // entries; with decode stalled it stops issue at two words.
  assign w_occ   = w_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = rst_n && (r_state == RUN) && !redirect_valid && (w_occ < 2'd2);

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_pc[AW+1:2];

  assign w_entry.instruction = ENTRY_INST_W'(mem_instruction);
  assign w_entry.pc          = r_inflight_pc;

  assign out_instruction = out_valid ? INST_WIDTH'(w_head.instruction) : '0;
  assign out_pc          = out_valid ? w_head.pc : RESET_PC;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = r_misaligned;
`else
  assign fetch_misaligned = 1'b0;
  logic w_unused_lo;
  assign w_unused_lo = ^redirect_pc[1:0];
`endif

  fetch_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_kill),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Fetch FSM: pc sequencing, in-flight tracking and redirect handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          r_state      <= HALT;
          r_misaligned <= 1'b1;
        end else begin
          r_state      <= RUN;
          r_misaligned <= 1'b0;
          r_pc         <= redirect_pc;
        end
`else
        r_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
`endif
      end else if (w_issue) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  // Remember which pc the outstanding read belongs to.
  always_ff @(posedge clk) begin
    if (w_issue) r_inflight_pc <= r_pc;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle-latency memory model
// holding word i = 32'h1000 + i; the model drives 32'hDEADBEEF when not read.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [31:0] mem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        fetch_misaligned;

  int          vecs;
  int          errs;
  logic [31:0] exp_pc;
  logic [31:0] exp_ins;

  instruction_fetch #(
    .INST_WIDTH (32),
    .INST_DEPTH (16),
    .RESET_PC   (32'h0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_instruction  (mem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_instruction <= mem_rd_en ? (32'h1000 + {28'd0, mem_rd_addr}) : 32'hDEADBEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) tick();
    vecs++; if (mem_rd_en !== 1'b0) begin errs++; $display("FAIL rst_rd_en got %b want 0", mem_rd_en); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vecs++; if (out_instruction !== 32'h0) begin errs++; $display("FAIL rst_out_ins got %h want 0", out_instruction); end
    vecs++; if (out_pc !== 32'h0) begin errs++; $display("FAIL rst_out_pc got %h want 0", out_pc); end
    vecs++; if (fetch_misaligned !== 1'b0) begin errs++; $display("FAIL rst_misaligned got %b want 0", fetch_misaligned); end
    rst_n = 1'b1;
    #1;
    vecs++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 4'd0) begin
      errs++; $display("FAIL pre_e1_issue got en=%b addr=%0d want en=1 addr=0", mem_rd_en, mem_rd_addr);
    end
  endtask

  task automatic test_stream();
    exp_pc = 32'h0;
    tick();  // E1
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL e1_out_valid got %b want 0", out_valid); end
    vecs++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 4'd1) begin
      errs++; $display("FAIL e1_issue got en=%b addr=%0d want en=1 addr=1", mem_rd_en, mem_rd_addr);
    end
    for (int k = 2; k <= 21; k++) begin
      tick();
      exp_ins = 32'h1000 + ((exp_pc >> 2) & 32'hF);
      vecs++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instruction !== exp_ins) begin
        errs++; $display("FAIL stream_k%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         k, out_valid, out_pc, out_instruction, exp_pc, exp_ins);
      end
      vecs++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 4'(k)) begin
        errs++; $display("FAIL stream_addr_k%0d got en=%b addr=%0d want en=1 addr=%0d",
                         k, mem_rd_en, mem_rd_addr, k % 16);
      end
      if (k == 18) begin
        vecs++; if (out_pc !== 32'd64 || out_instruction !== 32'h1000) begin
          errs++; $display("FAIL wrap_word got pc=%h ins=%h want pc=40 ins=1000", out_pc, out_instruction);
        end
      end
      if (k < 21) exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_backpressure();
    // exp_pc (76) is on the outputs and is not taken this cycle
    out_ready = 1'b0;
    #1;
    vecs++; if (mem_rd_en !== 1'b0) begin errs++; $display("FAIL bp_stop_issue got %b want 0", mem_rd_en); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++; if (out_valid !== 1'b1 || out_pc !== exp_pc || mem_rd_en !== 1'b0) begin
        errs++; $display("FAIL bp_hold_%0d got v=%b pc=%h en=%b want v=1 pc=%h en=0",
                         i, out_valid, out_pc, mem_rd_en, exp_pc);
      end
    end
    out_ready = 1'b1;
    #1;
    vecs++; if (mem_rd_en !== 1'b1) begin errs++; $display("FAIL bp_resume_issue got %b want 1", mem_rd_en); end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_pc  = exp_pc + 32'd4;
      exp_ins = 32'h1000 + ((exp_pc >> 2) & 32'hF);
      vecs++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instruction !== exp_ins) begin
        errs++; $display("FAIL bp_resume_%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         i, out_valid, out_pc, out_instruction, exp_pc, exp_ins);
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    #1;
    vecs++; if (mem_rd_en !== 1'b0) begin errs++; $display("FAIL redir_block_issue got %b want 0", mem_rd_en); end
    tick();  // R
    redirect_valid = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL redir_flush got v=%b want 0", out_valid); end
    #1;
    vecs++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 4'd8) begin
      errs++; $display("FAIL redir_issue got en=%b addr=%0d want en=1 addr=8", mem_rd_en, mem_rd_addr);
    end
    tick();  // R+1
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL redir_r1 got v=%b want 0", out_valid); end
    tick();  // R+2
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instruction !== 32'h1008) begin
      errs++; $display("FAIL redir_target got v=%b pc=%h ins=%h want v=1 pc=20 ins=1008",
                       out_valid, out_pc, out_instruction);
    end
    tick();
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h24 || out_instruction !== 32'h1009) begin
      errs++; $display("FAIL redir_next got v=%b pc=%h ins=%h want v=1 pc=24 ins=1009",
                       out_valid, out_pc, out_instruction);
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    #1;
    vecs++; if (fetch_misaligned !== 1'b1 || out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      errs++; $display("FAIL mis_halt got flag=%b v=%b en=%b want 1 0 0", fetch_misaligned, out_valid, mem_rd_en);
    end
    repeat (2) tick();
    vecs++; if (fetch_misaligned !== 1'b1 || out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      errs++; $display("FAIL mis_stay got flag=%b v=%b en=%b want 1 0 0", fetch_misaligned, out_valid, mem_rd_en);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0;
    vecs++; if (fetch_misaligned !== 1'b0) begin errs++; $display("FAIL mis_clear got %b want 0", fetch_misaligned); end
    repeat (2) tick();
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instruction !== 32'h1002) begin
      errs++; $display("FAIL mis_recover got v=%b pc=%h ins=%h want v=1 pc=8 ins=1002",
                       out_valid, out_pc, out_instruction);
    end
`else
    vecs++; if (fetch_misaligned !== 1'b0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL mis_noflag got flag=%b v=%b want 0 0", fetch_misaligned, out_valid);
    end
    #1;
    vecs++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 4'd8) begin
      errs++; $display("FAIL mis_align_issue got en=%b addr=%0d want en=1 addr=8", mem_rd_en, mem_rd_addr);
    end
    repeat (2) tick();
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instruction !== 32'h1008) begin
      errs++; $display("FAIL mis_align_fetch got v=%b pc=%h ins=%h want v=1 pc=20 ins=1008",
                       out_valid, out_pc, out_instruction);
    end
    tick();
    vecs++; if (out_pc !== 32'h24 || out_instruction !== 32'h1009) begin
      errs++; $display("FAIL mis_align_next got pc=%h ins=%h want pc=24 ins=1009", out_pc, out_instruction);
    end
`endif
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    repeat (3) tick();
    vecs++; if (out_valid !== 1'b1 || mem_rd_en !== 1'b0) begin
      errs++; $display("FAIL mr_full got v=%b en=%b want v=1 en=0", out_valid, mem_rd_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || out_instruction !== 32'h0 || out_pc !== 32'h0 ||
                mem_rd_en !== 1'b0 || fetch_misaligned !== 1'b0) begin
      errs++; $display("FAIL mr_async got v=%b ins=%h pc=%h en=%b flag=%b want all zero",
                       out_valid, out_instruction, out_pc, mem_rd_en, fetch_misaligned);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    vecs++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 4'd0) begin
      errs++; $display("FAIL mr_restart_issue got en=%b addr=%0d want en=1 addr=0", mem_rd_en, mem_rd_addr);
    end
    tick();  // E1
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mr_e1 got v=%b want 0", out_valid); end
    tick();  // E2
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== 32'h1000) begin
      errs++; $display("FAIL mr_first got v=%b pc=%h ins=%h want v=1 pc=0 ins=1000",
                       out_valid, out_pc, out_instruction);
    end
    tick();
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instruction !== 32'h1001) begin
      errs++; $display("FAIL mr_second got v=%b pc=%h ins=%h want v=1 pc=4 ins=1001",
                       out_valid, out_pc, out_instruction);
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
